pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives `PC_shouldstall` into the PC register and the stall/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Hazards it resolves:
- load-use and branch-operand data hazards detected in ID;
- multi-cycle data-memory waits;
- fixed-latency multiply/divide occupancy of EX;
- taken-branch redirects.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/md_lat_counter.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int RA_W     = 5;
    localparam int MD_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BL_HOLD = 2'd1,
        MD_WAIT = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter tracking remaining mul/div EX occupancy; tc_o flags the last cycle.
module md_lat_counter
    import pipe_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                hold_i,
    output logic                tc_o
);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Mul/div occupancy tracking is built only when PIPE_MULDIV_EN is defined.
//
// state   | meaning
// IDLE    | no multi-cycle hazard pending
// BL_HOLD | second bubble of a branch waiting on a load that was in EX
// MD_WAIT | mul/div still occupying EX
module pipe_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int RA_W   = pipe_ctrl_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            id_branch,
    input  logic            id_branch_taken,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_mem_read,
    input  logic            mem_busy,
    input  logic            md_start,
    output logic            PC_shouldstall,
    output logic            IFID_stall,
    output logic            IFID_flush,
    output logic            IDEX_stall,
    output logic            IDEX_flush,
    output logic            EXMEM_stall,
    output logic            EXMEM_flush,
    output logic            MEMWB_flush,
    output logic            md_busy
);
    import pipe_ctrl_pkg::*;

    pipe_state_e state_q, state_d;

    logic raw_ex, raw_mem;
    logic lu, ba, bl2, bl1, hazard;
    logic md_load, md_tc, md_wait;

    // x0 is hardwired, so a match against it is never a real dependency
    assign raw_ex  = (ex_rd != '0) &&
                     ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign raw_mem = (mem_rd != '0) &&
                     ((id_rs1_used && id_rs1 == mem_rd) || (id_rs2_used && id_rs2 == mem_rd));

    assign lu     = ex_mem_read && raw_ex;
    assign ba     = id_branch && ex_reg_write && !ex_mem_read && raw_ex;
    assign bl2    = id_branch && ex_mem_read && raw_ex;
    assign bl1    = id_branch && mem_mem_read && raw_mem;
    assign hazard = lu || ba || bl2 || bl1 || (state_q == BL_HOLD);

`ifdef PIPE_MULDIV_EN
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

    logic md_hold;

    assign md_load = (state_q == IDLE) && md_start && !mem_busy;
    assign md_hold = mem_busy || (state_q != MD_WAIT);
    assign md_wait = (state_q == MD_WAIT);

    md_lat_counter u_md_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (md_load),
        .load_val_i (MD_LOAD),
        .hold_i     (md_hold),
        .tc_o       (md_tc)
    );
`else
    localparam int unused_md_lat = MD_LAT;

    logic unused_md_start;

    assign unused_md_start = md_start;
    assign md_load         = 1'b0;
    assign md_tc           = 1'b0;
    assign md_wait         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (!mem_busy) begin
            case (state_q)
                IDLE: begin
                    if (md_load) begin
                        state_d = MD_WAIT;
                    end else if (bl2) begin
                        state_d = BL_HOLD;
                    end
                end
                BL_HOLD: state_d = IDLE;
                MD_WAIT: begin
                    if (md_tc) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A taken branch only redirects when nothing above it is holding ID
    always_comb begin
        PC_shouldstall = 1'b0;
        IFID_stall     = 1'b0;
        IFID_flush     = 1'b0;
        IDEX_stall     = 1'b0;
        IDEX_flush     = 1'b0;
        EXMEM_stall    = 1'b0;
        EXMEM_flush    = 1'b0;
        MEMWB_flush    = 1'b0;
        md_busy        = 1'b0;
        if (rst) begin
            md_busy = md_wait;
            if (mem_busy) begin
                PC_shouldstall = 1'b1;
                IFID_stall     = 1'b1;
                IDEX_stall     = 1'b1;
                EXMEM_stall    = 1'b1;
                MEMWB_flush    = 1'b1;
            end else if (md_wait) begin
                PC_shouldstall = 1'b1;
                IFID_stall     = 1'b1;
                IDEX_stall     = 1'b1;
                EXMEM_flush    = 1'b1;
            end else if (hazard) begin
                PC_shouldstall = 1'b1;
                IFID_stall     = 1'b1;
                IDEX_flush     = 1'b1;
            end else if (id_branch_taken) begin
                IFID_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus queues expected outputs, a monitor compares each cycle.
module tb_pipe_stall_ctrl;

    localparam int RA_W = 5;

`ifdef PIPE_MULDIV_EN
    localparam bit MDEN = 1'b1;
`else
    localparam bit MDEN = 1'b0;
`endif

    // {PC, IFID_s, IFID_f, IDEX_s, IDEX_f, EXMEM_s, EXMEM_f, MEMWB_f, md_busy}
    localparam logic [8:0] O_NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_HAZ  = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] O_FL   = 9'b0_0_1_0_0_0_0_0_0;
    localparam logic [8:0] O_MEMB = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] O_MD   = 9'b1_1_0_1_0_0_1_0_1;
    localparam logic [8:0] O_BUSY = 9'b0_0_0_0_0_0_0_0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic            id_rs1_used, id_rs2_used, id_branch, id_branch_taken;
    logic            ex_reg_write, ex_mem_read, mem_mem_read, mem_busy, md_start;
    logic            PC_shouldstall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush;
    logic            EXMEM_stall, EXMEM_flush, MEMWB_flush, md_busy;

    pipe_stall_ctrl #(.MD_LAT(4), .RA_W(RA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_branch       (id_branch),
        .id_branch_taken (id_branch_taken),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .mem_mem_read    (mem_mem_read),
        .mem_busy        (mem_busy),
        .md_start        (md_start),
        .PC_shouldstall  (PC_shouldstall),
        .IFID_stall      (IFID_stall),
        .IFID_flush      (IFID_flush),
        .IDEX_stall      (IDEX_stall),
        .IDEX_flush      (IDEX_flush),
        .EXMEM_stall     (EXMEM_stall),
        .EXMEM_flush     (EXMEM_flush),
        .MEMWB_flush     (MEMWB_flush),
        .md_busy         (md_busy)
    );

    logic [8:0] obs;
    assign obs = {PC_shouldstall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
                  EXMEM_stall, EXMEM_flush, MEMWB_flush, md_busy};

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_vec = 0;
    int  n_bad = 0;

    function automatic logic [8:0] mdx(input logic [8:0] alt);
        return MDEN ? O_MD : alt;
    endfunction

    task automatic quiet();
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_branch = 1'b0; id_branch_taken = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_mem_read = 1'b0; mem_busy = 1'b0; md_start = 1'b0;
    endtask

    task automatic step(input string nm, input logic [8:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        quiet();
    endtask

    task automatic lu_in();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    task automatic bl2_in();
        id_branch = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd7;
    endtask

    task automatic bl1_in();
        id_branch = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        mem_mem_read = 1'b1; mem_rd = 5'd7;
    endtask

    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                n_vec++;
                if (obs !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", e.nm, obs, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", sbq.size());
        $fatal(1);
    end

    initial begin
        quiet();
        rst = 1'b0;
        @(posedge clk);
        #1;

        rst = 1'b0; step("reset_idle", O_NONE);
        rst = 1'b0; lu_in(); mem_busy = 1'b1; id_branch_taken = 1'b1; step("reset_gates", O_NONE);
        step("idle", O_NONE);

        lu_in(); step("lu_rs1", O_HAZ);
        step("lu_one_cycle", O_NONE);
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1'b1;
        id_rs1 = 5'd3; id_rs1_used = 1'b1; step("lu_rs2", O_HAZ);
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; step("lu_rs2_unused", O_NONE);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1; step("x0_guard", O_NONE);

        id_branch = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        step("ba", O_HAZ);
        step("ba_one_cycle", O_NONE);
        ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1; step("alu_fwd", O_NONE);

        bl2_in(); step("bl2_c1", O_HAZ);
        bl1_in(); step("bl2_c2", O_HAZ);
        id_branch = 1'b1; id_branch_taken = 1'b1; step("bl2_taken", O_FL);
        bl2_in(); step("bl2_c1b", O_HAZ);
        step("bl_hold_alone", O_HAZ);
        step("bl_hold_exit", O_NONE);
        bl1_in(); step("bl1", O_HAZ);
        step("bl1_no_hold", O_NONE);
        id_branch = 1'b1; id_branch_taken = 1'b1; step("taken", O_FL);

        mem_busy = 1'b1; lu_in(); id_branch_taken = 1'b1; step("busy_prio", O_MEMB);
        bl2_in(); mem_busy = 1'b1; step("bl2_busy", O_MEMB);
        step("bl2_busy_no_hold", O_NONE);
        bl2_in(); step("bl2_c1c", O_HAZ);
        mem_busy = 1'b1; step("hold_busy", O_MEMB);
        step("hold_after_busy", O_HAZ);
        step("hold_done", O_NONE);

        md_start = 1'b1; step("md_start", O_NONE);
        for (int i = 1; i <= 3; i++) step($sformatf("md_wait%0d", i), mdx(O_NONE));
        step("md_done", O_NONE);

        md_start = 1'b1; step("md2_start", O_NONE);
        step("md2_w1", mdx(O_NONE));
        mem_busy = 1'b1; step("md2_busy1", MDEN ? (O_MEMB | O_BUSY) : O_MEMB);
        mem_busy = 1'b1; step("md2_busy2", MDEN ? (O_MEMB | O_BUSY) : O_MEMB);
        step("md2_w2", mdx(O_NONE));
        step("md2_w3", mdx(O_NONE));
        step("md2_done", O_NONE);

        md_start = 1'b1; step("md3_start", O_NONE);
        md_start = 1'b1; lu_in(); step("md3_lu", mdx(O_HAZ));
        md_start = 1'b1; id_branch = 1'b1; id_branch_taken = 1'b1; step("md3_taken", mdx(O_FL));
        md_start = 1'b1; step("md3_ignore", mdx(O_NONE));
        step("md3_done", O_NONE);

        md_start = 1'b1; step("md4_start", O_NONE);
        step("md4_w1", mdx(O_NONE));
        rst = 1'b0; step("md4_rst", O_NONE);
        step("md4_after_rst", O_NONE);
        step("md4_idle", O_NONE);

        bl2_in(); step("bl5_c1", O_HAZ);
        rst = 1'b0; step("bl5_rst", O_NONE);
        step("bl5_after_rst", O_NONE);

        for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d vectors left unchecked, required 0", sbq.size());
            n_bad += sbq.size();
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
